// File: rtl/pipelined_write_rx.sv
// Receive stage for the pipelined write stream: assembles a command plus 1-4 data
// beats into a 32-bit write, queues it in a small FIFO, and raises wdone/error flags.
module pipelined_write_rx #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pw_bus,
  output logic        wr_vld,
  input  logic        wr_rdy,
  output logic [31:0] wr_data,
  output logic [2:0]  wr_len,
  output logic [2:0]  wr_type,
  output logic        wdone,
  output logic        err_proto,
  output logic        err_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] WT_MULTI  = 3'd1;
  localparam logic [2:0] WT_SINGLE = 3'd2;
  localparam logic [1:0] CT_IDLE   = 2'd0;
  localparam logic [1:0] CT_VALID  = 2'd1;
  localparam logic [1:0] CT_DONE   = 2'd2;

  typedef enum logic {CMD, DATA} state_t;

  state_t      state_p0, state_nxt;
  logic [1:0]  cnt_p0, last_p0;
  logic [2:0]  type_p0;
  logic [31:0] asm_p0, fin_data;
  logic        load_cmd, store_beat, complete, proto_err;

  logic        cmd_val;
  logic [1:0]  cmd_num, cyc;
  logic [2:0]  cmd_type;
  logic [7:0]  dat;

  assign cmd_val  = pw_bus[5];
  assign cmd_num  = pw_bus[4:3];
  assign cmd_type = pw_bus[2:0];
  assign cyc      = pw_bus[9:8];
  assign dat      = pw_bus[7:0];

  logic [31:0] mem_data [FIFO_DEPTH];
  logic [2:0]  mem_len  [FIFO_DEPTH];
  logic [2:0]  mem_type [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, push;

  always_comb begin
    state_nxt  = state_p0;
    load_cmd   = 1'b0;
    store_beat = 1'b0;
    complete   = 1'b0;
    proto_err  = 1'b0;
    case (state_p0)
      CMD: begin
        if (cmd_val) begin
          if (cmd_type > WT_SINGLE) begin
            proto_err = 1'b1;
          end else begin
            load_cmd  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        // Beat count never exceeds last index, so "count < N-1" reduces to inequality.
        if (cyc == CT_VALID && cnt_p0 != last_p0) begin
          store_beat = 1'b1;
        end else if (cyc == CT_DONE && cnt_p0 == last_p0) begin
          complete  = 1'b1;
          state_nxt = CMD;
        end else if (cyc != CT_IDLE) begin
          proto_err = 1'b1;
          state_nxt = CMD;
        end
      end
      default: state_nxt = CMD;
    endcase
  end

  always_comb begin
    fin_data = asm_p0;
    fin_data[{cnt_p0, 3'b000} +: 8] = dat;
  end

  assign wr_vld = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = wr_vld & wr_rdy;
  assign push   = complete & (~full | pop);

  assign wr_data = wr_vld ? mem_data[rd_ptr[AW-1:0]] : 32'd0;
  assign wr_len  = wr_vld ? mem_len[rd_ptr[AW-1:0]]  : 3'd0;
  assign wr_type = wr_vld ? mem_type[rd_ptr[AW-1:0]] : 3'd0;

  // Control state: FSM, beat counter, FIFO pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0  <= CMD;
      cnt_p0    <= 2'd0;
      last_p0   <= 2'd0;
      type_p0   <= 3'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wdone     <= 1'b0;
      err_proto <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (load_cmd) begin
        cnt_p0  <= 2'd0;
        last_p0 <= cmd_num - 2'd1;
        type_p0 <= cmd_type;
      end else if (store_beat) begin
        cnt_p0 <= cnt_p0 + 2'd1;
      end
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      wdone     <= ((type_p0 == WT_MULTI) && (store_beat || complete)) ||
                   ((type_p0 == WT_SINGLE) && push);
      err_proto <= proto_err;
      if (complete && !push) err_ovf <= 1'b1;
    end
  end

  // Datapath: assembly register and FIFO storage carry no reset.
  always_ff @(posedge clk) begin
    if (load_cmd) begin
      asm_p0 <= 32'd0;
    end else if (store_beat) begin
      asm_p0[{cnt_p0, 3'b000} +: 8] <= dat;
    end
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= fin_data;
      mem_len[wr_ptr[AW-1:0]]  <= {1'b0, last_p0} + 3'd1;
      mem_type[wr_ptr[AW-1:0]] <= type_p0;
    end
  end

endmodule
